// File: rtl/uart_msg_tx_if.sv
// Request/BRAM-read bundle between the message core/arbiter and uart_msg_tx.
// The slave side is the transmitter. The master side is the core plus the BRAM read port.
interface uart_msg_tx_if #(
  parameter int WIDTH = 8,
  parameter int LEN   = 256
);
  localparam int AW = $clog2(LEN);

  logic          start;
  logic [AW-1:0] base;
  logic [AW:0]   len;
  logic [AW-1:0] addr;
  logic [WIDTH-1:0] dout;
  logic          busy;
  logic          done;

  modport slave  (input start, base, len, dout, output addr, busy, done);
  modport master (output start, base, len, dout, input addr, busy, done);
endinterface

// File: rtl/uart_msg_tx.sv
// Streams len bytes from BRAM starting at base onto an 8N1 UART line, LSB first.
// Frames are sent back to back, and done pulses one cycle after the final stop bit.
module uart_msg_tx #(
  parameter int WIDTH        = 8,
  parameter int LEN          = 256,
  parameter int CLKS_PER_BIT = 104
) (
  input  logic              clk,
  input  logic              rst_n,
  uart_msg_tx_if.slave      bus,
  output logic              TX
);
  localparam int AW = $clog2(LEN);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, START, DATA, STOP, FIN} state_t;

  state_t           state_q;
  logic             tx_q, busy_q, done_q;
  logic [AW-1:0]    addr_q;
  logic [AW:0]      rem_q;
  logic [CW-1:0]    cnt_q;
  logic [BW-1:0]    bit_q;
  logic [WIDTH-1:0] sh_q;
  logic [AW-1:0]    addr_d;
  logic             last_clk;

  assign addr_d   = (addr_q == AW'(LEN - 1)) ? '0 : addr_q + 1'b1;
  assign last_clk = (cnt_q == CW'(CLKS_PER_BIT - 1));

  // TX is registered from the state, so the line lags the state by one clock.
  // That lag places the first start bit on the third clock edge after start is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      addr_q  <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (bus.start) begin
          busy_q  <= 1'b1;
          addr_q  <= bus.base;
          rem_q   <= bus.len;
          state_q <= (bus.len == '0) ? FIN : FETCH;
        end
        FETCH: state_q <= LOAD;
        LOAD: begin
          sh_q    <= bus.dout;
          addr_q  <= addr_d;
          rem_q   <= rem_q - 1'b1;
          cnt_q   <= '0;
          state_q <= START;
        end
        START: begin
          tx_q <= 1'b0;
          if (last_clk) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            state_q <= DATA;
          end else cnt_q <= cnt_q + 1'b1;
        end
        DATA: begin
          tx_q <= sh_q[0];
          if (last_clk) begin
            cnt_q <= '0;
            sh_q  <= sh_q >> 1;
            if (bit_q == BW'(WIDTH - 1)) state_q <= STOP;
            else bit_q <= bit_q + 1'b1;
          end else cnt_q <= cnt_q + 1'b1;
        end
        STOP: begin
          tx_q <= 1'b1;
          if (last_clk) begin
            cnt_q <= '0;
            if (rem_q == '0) state_q <= FIN;
            else begin
              // The address has already advanced, so dout holds the next byte here.
              sh_q    <= bus.dout;
              addr_q  <= addr_d;
              rem_q   <= rem_q - 1'b1;
              state_q <= START;
            end
          end else cnt_q <= cnt_q + 1'b1;
        end
        FIN: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign TX       = tx_q;
  assign bus.addr = addr_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
endmodule
